// File: rtl/vx_csr_multi_unit_if.sv
// Dispatch, CSR backend and commit bundle for vx_csr_multi_unit.
// The unit is the slave side; the issue stage, backend and commit form the master side.
interface vx_csr_multi_unit_if #(
    parameter int NUM_REQS    = 2,
    parameter int NUM_THREADS = 4,
    parameter int NUM_WARPS   = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int UUID_BITS   = 44,
    parameter int PC_BITS     = 32
);
    localparam int NT_BITS  = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
    localparam int NW_BITS  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int IDX_BITS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    logic [NUM_REQS-1:0]                                  req_valid;
    logic [NUM_REQS-1:0]                                  req_ready;
    logic [NUM_REQS-1:0][UUID_BITS-1:0]                   req_uuid;
    logic [NUM_REQS-1:0][NW_BITS-1:0]                     req_wid;
    logic [NUM_REQS-1:0][NUM_THREADS-1:0]                 req_tmask;
    logic [NUM_REQS-1:0][PC_BITS-1:0]                     req_pc;
    logic [NUM_REQS-1:0][4:0]                             req_rd;
    logic [NUM_REQS-1:0]                                  req_wb;
    logic [NUM_REQS-1:0][1:0]                             req_op_type;
    logic [NUM_REQS-1:0][11:0]                            req_addr;
    logic [NUM_REQS-1:0]                                  req_use_imm;
    logic [NUM_REQS-1:0][4:0]                             req_imm;
    logic [NUM_REQS-1:0][NT_BITS-1:0]                     req_tid;
    logic [NUM_REQS-1:0][NUM_THREADS-1:0][DATA_WIDTH-1:0] req_rs1_data;
    logic                                                 access_pending;

    logic                  be_read_enable;
    logic                  be_write_enable;
    logic [11:0]           be_addr;
    logic [NW_BITS-1:0]    be_wid;
    logic [UUID_BITS-1:0]  be_uuid;
    logic [DATA_WIDTH-1:0] be_read_data_ro;
    logic [DATA_WIDTH-1:0] be_read_data_rw;
    logic [DATA_WIDTH-1:0] be_write_data;

    logic                                   rsp_valid;
    logic                                   rsp_ready;
    logic [IDX_BITS-1:0]                    rsp_idx;
    logic [UUID_BITS-1:0]                   rsp_uuid;
    logic [NW_BITS-1:0]                     rsp_wid;
    logic [NUM_THREADS-1:0]                 rsp_tmask;
    logic [PC_BITS-1:0]                     rsp_pc;
    logic [4:0]                             rsp_rd;
    logic                                   rsp_wb;
    logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] rsp_data;
    logic                                   req_pending;

    modport master (
        output req_valid, req_uuid, req_wid, req_tmask, req_pc, req_rd, req_wb,
               req_op_type, req_addr, req_use_imm, req_imm, req_tid, req_rs1_data,
               access_pending, be_read_data_ro, be_read_data_rw, rsp_ready,
        input  req_ready, be_read_enable, be_write_enable, be_addr, be_wid, be_uuid,
               be_write_data, rsp_valid, rsp_idx, rsp_uuid, rsp_wid, rsp_tmask,
               rsp_pc, rsp_rd, rsp_wb, rsp_data, req_pending
    );

    modport slave (
        input  req_valid, req_uuid, req_wid, req_tmask, req_pc, req_rd, req_wb,
               req_op_type, req_addr, req_use_imm, req_imm, req_tid, req_rs1_data,
               access_pending, be_read_data_ro, be_read_data_rw, rsp_ready,
        output req_ready, be_read_enable, be_write_enable, be_addr, be_wid, be_uuid,
               be_write_data, rsp_valid, rsp_idx, rsp_uuid, rsp_wid, rsp_tmask,
               rsp_pc, rsp_rd, rsp_wb, rsp_data, req_pending
    );
endinterface

// File: rtl/vx_csr_multi_unit.sv
// Multi-port CSR unit: round-robin pick of one CSR instruction per cycle, local ID and
// per-warp scratch CSRs, backend access for the rest, responses buffered in a small FIFO.
module vx_csr_multi_unit #(
    parameter int          CORE_ID          = 0,
    parameter int          NUM_REQS         = 2,
    parameter int          NUM_THREADS      = 4,
    parameter int          NUM_WARPS        = 4,
    parameter int          DATA_WIDTH       = 32,
    parameter int          RSP_DEPTH        = 4,
    parameter int          NUM_SCRATCH      = 4,
    parameter int          UUID_BITS        = 44,
    parameter int          PC_BITS          = 32,
    parameter logic [11:0] CSR_WTID         = 12'hCC0,
    parameter logic [11:0] CSR_LTID         = 12'hCC1,
    parameter logic [11:0] CSR_GTID         = 12'hCC2,
    parameter logic [11:0] CSR_LWID         = 12'hCC3,
    parameter logic [11:0] CSR_GWID         = 12'hCC4,
    parameter logic [11:0] CSR_SCRATCH_BASE = 12'hCD0
) (
    input logic                clk,
    input logic                reset,
    vx_csr_multi_unit_if.slave bus
);
    localparam logic [1:0] INST_CSR_RW = 2'd1;
    localparam logic [1:0] INST_CSR_RS = 2'd2;

    localparam int NT_BITS  = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
    localparam int NW_BITS  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int IDX_BITS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
    localparam int SC_BITS  = (NUM_SCRATCH > 1) ? $clog2(NUM_SCRATCH) : 1;
    localparam int PTR_BITS = $clog2(RSP_DEPTH);
    localparam int CNT_BITS = $clog2(RSP_DEPTH + 1);

    typedef logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] tdata_t;

    typedef struct packed {
        logic [IDX_BITS-1:0]    idx;
        logic [UUID_BITS-1:0]   uuid;
        logic [NW_BITS-1:0]     wid;
        logic [NUM_THREADS-1:0] tmask;
        logic [PC_BITS-1:0]     pc;
        logic [4:0]             rd;
        logic                   wb;
        tdata_t                 data;
    } rsp_entry_t;

    logic [IDX_BITS-1:0] rr, grant_idx;
    logic                grant_valid;
    logic [NUM_REQS-1:0] rr_reach;
    logic                accept, push, pop;
    logic [CNT_BITS-1:0] q_count;
    logic [PTR_BITS-1:0] wr_ptr, rd_ptr;
    rsp_entry_t          q_mem [RSP_DEPTH];
    rsp_entry_t          q_head;
    logic [DATA_WIDTH-1:0] scratch [NUM_WARPS][NUM_SCRATCH];

    logic [UUID_BITS-1:0]   g_uuid;
    logic [NW_BITS-1:0]     g_wid;
    logic [1:0]             g_op;
    logic [11:0]            g_addr, addr_off;
    logic [NT_BITS-1:0]     g_tid;
    tdata_t                 g_rs1, rsp_data_n;
    logic                   is_id, is_scratch, is_backend, do_write;
    logic [SC_BITS-1:0]     sc_idx;
    logic [DATA_WIDTH-1:0]  src, old_val, new_val;

    function automatic logic [IDX_BITS-1:0] rr_port(input logic [IDX_BITS-1:0] base, input int k);
        int p;
        p = (int'(base) + k) % NUM_REQS;
        return IDX_BITS'(p);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] id_value(input logic [11:0] addr,
                                                       input logic [NW_BITS-1:0] wid,
                                                       input int tid);
        logic [DATA_WIDTH-1:0] ltid;
        ltid = (DATA_WIDTH'(wid) << NT_BITS) + DATA_WIDTH'(tid);
        case (addr)
            CSR_WTID: return DATA_WIDTH'(tid);
            CSR_LTID: return ltid;
            CSR_GTID: return (DATA_WIDTH'(CORE_ID) << (NW_BITS + NT_BITS)) + ltid;
            CSR_LWID: return DATA_WIDTH'(wid);
            default:  return (DATA_WIDTH'(CORE_ID) << NW_BITS) + DATA_WIDTH'(wid);
        endcase
    endfunction

    // rr_reach[i] only looks at ports ahead of i in rotation order, so req_ready[i]
    // never depends on req_valid[i] itself.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        grant_valid = 1'b0;
        grant_idx   = rr;
        rr_reach    = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            if (!grant_valid) begin
                rr_reach[rr_port(rr, k)] = 1'b1;
                if (bus.req_valid[rr_port(rr, k)]) begin
                    grant_valid = 1'b1;
                    grant_idx   = rr_port(rr, k);
                end
            end
        end
    end

    assign pop           = (q_count != '0) && bus.rsp_ready;
    assign accept        = reset && !bus.access_pending
                           && ((q_count != CNT_BITS'(RSP_DEPTH)) || pop);
    assign bus.req_ready = rr_reach & {NUM_REQS{accept}};
    assign push          = accept && grant_valid;

    assign g_uuid = bus.req_uuid[grant_idx];
    assign g_wid  = bus.req_wid[grant_idx];
    assign g_op   = bus.req_op_type[grant_idx];
    assign g_addr = bus.req_addr[grant_idx];
    assign g_tid  = bus.req_tid[grant_idx];
    assign g_rs1  = bus.req_rs1_data[grant_idx];

    assign addr_off   = g_addr - CSR_SCRATCH_BASE;
    assign sc_idx     = SC_BITS'(addr_off);
    assign is_scratch = (g_addr >= CSR_SCRATCH_BASE) && (addr_off < 12'(NUM_SCRATCH));
    assign is_id      = (g_addr == CSR_WTID) || (g_addr == CSR_LTID) || (g_addr == CSR_GTID)
                        || (g_addr == CSR_LWID) || (g_addr == CSR_GWID);
    assign is_backend = !is_id && !is_scratch;

    always_comb begin
        src      = bus.req_use_imm[grant_idx] ? DATA_WIDTH'(bus.req_imm[grant_idx]) : g_rs1[g_tid];
        old_val  = is_scratch ? scratch[g_wid][sc_idx] : bus.be_read_data_rw;
        do_write = (g_op == INST_CSR_RW) || (src != '0);
        case (g_op)
            INST_CSR_RW: new_val = src;
            INST_CSR_RS: new_val = old_val | src;
            default:     new_val = old_val & ~src;
        endcase
    end

    always_comb begin
        for (int t = 0; t < NUM_THREADS; t++) begin
            if (is_id)           rsp_data_n[t] = id_value(g_addr, g_wid, t);
            else if (is_scratch) rsp_data_n[t] = old_val;
            else                 rsp_data_n[t] = bus.be_read_data_ro | bus.be_read_data_rw;
        end
    end

    assign bus.be_read_enable  = push && is_backend;
    assign bus.be_write_enable = push && is_backend && do_write;
    assign bus.be_addr         = g_addr;
    assign bus.be_wid          = g_wid;
    assign bus.be_uuid         = g_uuid;
    assign bus.be_write_data   = new_val;

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            rr      <= '0;
            q_count <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            for (int w = 0; w < NUM_WARPS; w++)
                for (int s = 0; s < NUM_SCRATCH; s++)
                    scratch[w][s] <= '0;
        end else begin
            if (push) begin
                rr     <= (grant_idx == IDX_BITS'(NUM_REQS - 1)) ? '0 : grant_idx + 1'b1;
                wr_ptr <= (wr_ptr == PTR_BITS'(RSP_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
                if (is_scratch && do_write)
                    scratch[g_wid][sc_idx] <= new_val;
            end
            if (pop)
                rd_ptr <= (rd_ptr == PTR_BITS'(RSP_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            q_count <= q_count + CNT_BITS'(push) - CNT_BITS'(pop);
        end
    end

    // NOTE: queue storage is not reset; q_count/pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[wr_ptr] <= '{idx:   grant_idx,
                               uuid:  g_uuid,
                               wid:   g_wid,
                               tmask: bus.req_tmask[grant_idx],
                               pc:    bus.req_pc[grant_idx],
                               rd:    bus.req_rd[grant_idx],
                               wb:    bus.req_wb[grant_idx],
                               data:  rsp_data_n};
        end
    end

    assign q_head          = q_mem[rd_ptr];
    assign bus.rsp_valid   = (q_count != '0);
    assign bus.req_pending = (q_count != '0);
    assign bus.rsp_idx     = q_head.idx;
    assign bus.rsp_uuid    = q_head.uuid;
    assign bus.rsp_wid     = q_head.wid;
    assign bus.rsp_tmask   = q_head.tmask;
    assign bus.rsp_pc      = q_head.pc;
    assign bus.rsp_rd      = q_head.rd;
    assign bus.rsp_wb      = q_head.wb;
    assign bus.rsp_data    = q_head.data;
endmodule

// File: tb/tb_vx_csr_multi_unit.sv
// Randomized self-checking bench for vx_csr_multi_unit against a transaction-level model
// (per-port request queues, expected-response queue, scratch/backend arrays).
module tb_vx_csr_multi_unit;
    localparam int CORE_ID = 1, NUM_REQS = 2, NT = 4, NW = 4, DW = 32;
    localparam int RSP_DEPTH = 4, NUM_SCRATCH = 4;
    localparam logic [11:0] CSR_WTID = 12'hCC0, CSR_LTID = 12'hCC1, CSR_GTID = 12'hCC2;
    localparam logic [11:0] CSR_LWID = 12'hCC3, CSR_GWID = 12'hCC4, SCR = 12'hCD0;
    localparam logic [1:0] OP_RW = 2'd1, OP_RS = 2'd2, OP_RC = 2'd3;

    typedef struct {
        logic [43:0] uuid; logic [1:0] wid; logic [3:0] tmask; logic [31:0] pc;
        logic [4:0] rd; logic wb; logic [1:0] op; logic [11:0] addr;
        logic use_imm; logic [4:0] imm; logic [1:0] tid; logic [3:0][31:0] rs1;
    } req_t;

    typedef struct {
        int idx; logic [43:0] uuid; logic [1:0] wid; logic [3:0] tmask;
        logic [31:0] pc; logic [4:0] rd; logic wb; logic [127:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    vx_csr_multi_unit_if #(.NUM_REQS(NUM_REQS), .NUM_THREADS(NT), .NUM_WARPS(NW),
                           .DATA_WIDTH(DW), .UUID_BITS(44), .PC_BITS(32)) bus ();

    vx_csr_multi_unit #(.CORE_ID(CORE_ID), .NUM_REQS(NUM_REQS), .NUM_THREADS(NT),
                        .NUM_WARPS(NW), .DATA_WIDTH(DW), .RSP_DEPTH(RSP_DEPTH),
                        .NUM_SCRATCH(NUM_SCRATCH), .UUID_BITS(44), .PC_BITS(32),
                        .CSR_WTID(CSR_WTID), .CSR_LTID(CSR_LTID), .CSR_GTID(CSR_GTID),
                        .CSR_LWID(CSR_LWID), .CSR_GWID(CSR_GWID), .CSR_SCRATCH_BASE(SCR))
        dut (.clk(clk), .reset(reset), .bus(bus));

    // Backend CSR file: rw part is a memory, ro part is a fixed pattern of the address.
    logic [31:0] be_mem [4096];
    assign bus.be_read_data_rw = be_mem[bus.be_addr];
    assign bus.be_read_data_ro = {bus.be_addr, 20'h0};

    int n_checks = 0, n_errors = 0;
    req_t port_q [NUM_REQS][$];
    exp_t m_q[$];
    int m_rr = 0;
    logic [31:0] m_scratch [NW][NUM_SCRATCH];
    logic [43:0] uuid_ctr = '0;
    int grant_log[$], idx_log[$];
    logic [31:0] data_log[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic req_t mk(input logic [1:0] op, input logic [11:0] addr,
                                input logic [1:0] wid, input logic use_imm, input logic [4:0] imm);
        req_t r;
        uuid_ctr = uuid_ctr + 1;
        r.uuid = uuid_ctr; r.wid = wid; r.tmask = 4'($urandom); r.pc = $urandom;
        r.rd = 5'($urandom); r.wb = 1'($urandom); r.op = op; r.addr = addr;
        r.use_imm = use_imm; r.imm = imm; r.tid = 2'($urandom);
        for (int t = 0; t < NT; t++) r.rs1[t] = $urandom;
        return r;
    endfunction

    // Architectural effect of one accepted CSR instruction.
    function automatic exp_t model_exec(input req_t r, input int port, output logic be_rd,
                                        output logic be_wr, output logic [31:0] be_wdata);
        exp_t e;
        logic [31:0] src, old, nv;
        logic wr;
        int sidx;
        src = r.use_imm ? {27'd0, r.imm} : r.rs1[r.tid];
        wr = (r.op == OP_RW) || (src != 0);
        e.idx = port; e.uuid = r.uuid; e.wid = r.wid; e.tmask = r.tmask;
        e.pc = r.pc; e.rd = r.rd; e.wb = r.wb; e.data = '0;
        be_rd = 1'b0; be_wr = 1'b0; be_wdata = '0;
        if (r.addr >= CSR_WTID && r.addr <= CSR_GWID) begin
            for (int t = 0; t < NT; t++) begin
                case (r.addr)
                    CSR_WTID: e.data[t*32 +: 32] = t;
                    CSR_LTID: e.data[t*32 +: 32] = r.wid * NT + t;
                    CSR_GTID: e.data[t*32 +: 32] = CORE_ID * NW * NT + r.wid * NT + t;
                    CSR_LWID: e.data[t*32 +: 32] = r.wid;
                    default:  e.data[t*32 +: 32] = CORE_ID * NW + r.wid;
                endcase
            end
            return e;
        end
        if (r.addr >= SCR && r.addr < SCR + NUM_SCRATCH) begin
            sidx = int'(r.addr - SCR);
            old = m_scratch[r.wid][sidx];
        end else begin
            sidx = -1;
            old = be_mem[r.addr];
        end
        nv = (r.op == OP_RW) ? src : (r.op == OP_RS) ? (old | src) : (old & ~src);
        for (int t = 0; t < NT; t++)
            e.data[t*32 +: 32] = (sidx >= 0) ? old : ({r.addr, 20'h0} | old);
        if (sidx >= 0) begin
            if (wr) m_scratch[r.wid][sidx] = nv;
        end else begin
            be_rd = 1'b1; be_wr = wr; be_wdata = nv;
        end
        return e;
    endfunction

    task automatic drive_ports();
        for (int p = 0; p < NUM_REQS; p++) begin
            bus.req_valid[p] = (port_q[p].size() != 0);
            if (port_q[p].size() != 0) begin
                bus.req_uuid[p] = port_q[p][0].uuid;   bus.req_wid[p] = port_q[p][0].wid;
                bus.req_tmask[p] = port_q[p][0].tmask; bus.req_pc[p] = port_q[p][0].pc;
                bus.req_rd[p] = port_q[p][0].rd;       bus.req_wb[p] = port_q[p][0].wb;
                bus.req_op_type[p] = port_q[p][0].op;  bus.req_addr[p] = port_q[p][0].addr;
                bus.req_use_imm[p] = port_q[p][0].use_imm; bus.req_imm[p] = port_q[p][0].imm;
                bus.req_tid[p] = port_q[p][0].tid;     bus.req_rs1_data[p] = port_q[p][0].rs1;
            end
        end
    endtask

    // One clock: drive, sample at negedge against the model, advance past posedge.
    task automatic step();
        int g;
        logic pop, acc, hs, ber, bew;
        logic [31:0] bwd;
        logic [11:0] baddr;
        exp_t e;
        drive_ports();
        @(negedge clk);
        pop = (m_q.size() != 0) && bus.rsp_ready;
        check("rsp_valid", bus.rsp_valid, m_q.size() != 0);
        check("req_pending", bus.req_pending, m_q.size() != 0);
        if (m_q.size() != 0) begin
            check("rsp_idx", bus.rsp_idx, m_q[0].idx);
            check("rsp_uuid", bus.rsp_uuid, m_q[0].uuid);
            check("rsp_wid", bus.rsp_wid, m_q[0].wid);
            check("rsp_tmask", bus.rsp_tmask, m_q[0].tmask);
            check("rsp_pc", bus.rsp_pc, m_q[0].pc);
            check("rsp_rd_wb", {bus.rsp_rd, bus.rsp_wb}, {m_q[0].rd, m_q[0].wb});
            check("rsp_data", bus.rsp_data, m_q[0].data);
            if (pop) begin
                idx_log.push_back(int'(bus.rsp_idx));
                data_log.push_back(bus.rsp_data[0]);
            end
        end
        acc = !bus.access_pending && (m_q.size() < RSP_DEPTH || pop);
        g = -1;
        for (int k = 0; k < NUM_REQS; k++)
            if (g < 0 && port_q[(m_rr + k) % NUM_REQS].size() != 0) g = (m_rr + k) % NUM_REQS;
        hs = acc && (g >= 0);
        for (int p = 0; p < NUM_REQS; p++) begin
            if (port_q[p].size() != 0) check("req_ready", bus.req_ready[p], hs && (p == g));
            if (bus.req_valid[p] && bus.req_ready[p]) grant_log.push_back(p);
        end
        bew = 1'b0; bwd = '0; baddr = '0;
        if (hs) begin
            e = model_exec(port_q[g][0], g, ber, bew, bwd);
            baddr = port_q[g][0].addr;
            check("be_read_enable", bus.be_read_enable, ber);
            check("be_write_enable", bus.be_write_enable, bew);
            if (ber) begin
                check("be_addr", bus.be_addr, port_q[g][0].addr);
                check("be_wid_uuid", {bus.be_wid, bus.be_uuid}, {port_q[g][0].wid, port_q[g][0].uuid});
            end
            if (bew) check("be_write_data", bus.be_write_data, bwd);
        end else begin
            check("be_idle", {bus.be_read_enable, bus.be_write_enable}, 2'b00);
        end
        if (pop) void'(m_q.pop_front());
        if (hs) m_q.push_back(e);
        @(posedge clk);
        #1;
        if (hs) begin
            void'(port_q[g].pop_front());
            m_rr = (g + 1) % NUM_REQS;
            if (bew) be_mem[baddr] = bwd;
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((m_q.size() != 0 || port_q[0].size() != 0 || port_q[1].size() != 0) && n < budget) begin
            step();
            n++;
        end
        check("drain_left", m_q.size() + port_q[0].size() + port_q[1].size(), 0);
        step();
    endtask

    task automatic clear_logs();
        grant_log.delete(); idx_log.delete(); data_log.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int rr_before;
        int exp_rr[6];
        logic [31:0] exp_sc[5];
        req_t r;
        for (int a = 0; a < 4096; a++) be_mem[a] = '0;
        for (int w = 0; w < NW; w++) for (int s = 0; s < NUM_SCRATCH; s++) m_scratch[w][s] = '0;
        bus.req_valid = '0; bus.req_uuid = '0; bus.req_wid = '0; bus.req_tmask = '0;
        bus.req_pc = '0; bus.req_rd = '0; bus.req_wb = '0; bus.req_op_type = '0;
        bus.req_addr = '0; bus.req_use_imm = '0; bus.req_imm = '0; bus.req_tid = '0;
        bus.req_rs1_data = '0; bus.access_pending = 1'b0; bus.rsp_ready = 1'b1;

        // Reset state
        #12;
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_req_pending", bus.req_pending, 1'b0);
        check("rst_req_ready", bus.req_ready, 2'b00);
        check("rst_be_en", {bus.be_read_enable, bus.be_write_enable}, 2'b00);
        @(posedge clk); #1; reset = 1'b1;

        // Round-robin: grants and rsp_idx alternate 0,1,0,1,0,1
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            port_q[0].push_back(mk(OP_RS, CSR_LWID, 2'($urandom), 1'b1, 5'd0));
            port_q[1].push_back(mk(OP_RS, CSR_LWID, 2'($urandom), 1'b1, 5'd0));
        end
        drain(20);
        exp_rr = '{0, 1, 0, 1, 0, 1};
        check("rr_count", grant_log.size(), 6);
        check("rr_idx_count", idx_log.size(), 6);
        for (int i = 0; i < 6 && i < grant_log.size() && i < idx_log.size(); i++) begin
            check("rr_grant", grant_log[i], exp_rr[i]);
            check("rr_rsp_idx", idx_log[i], exp_rr[i]);
        end

        // Global thread ids for warp 2
        port_q[0].push_back(mk(OP_RS, CSR_GTID, 2'd2, 1'b1, 5'd0));
        drain(10);

        // Scratch read-modify-write on warp 1, then warp 0 isolation
        clear_logs();
        r = mk(OP_RW, SCR, 2'd1, 1'b0, 5'd0); r.tid = 2'd3; r.rs1[3] = 32'hF0;
        port_q[0].push_back(r);
        port_q[0].push_back(mk(OP_RS, SCR, 2'd1, 1'b1, 5'h03));
        port_q[0].push_back(mk(OP_RC, SCR, 2'd1, 1'b1, 5'h10));
        port_q[0].push_back(mk(OP_RS, SCR, 2'd1, 1'b1, 5'h00));
        port_q[0].push_back(mk(OP_RS, SCR, 2'd0, 1'b1, 5'h00));
        drain(20);
        exp_sc = '{32'h0, 32'hF0, 32'hF3, 32'hE3, 32'h0};
        check("sc_count", data_log.size(), 5);
        for (int i = 0; i < 5 && i < data_log.size(); i++) check("sc_data", data_log[i], exp_sc[i]);

        // Backend: pure read, write of 5, read back
        port_q[0].push_back(mk(OP_RS, 12'h300, 2'd0, 1'b1, 5'd0));
        port_q[0].push_back(mk(OP_RW, 12'h301, 2'd1, 1'b1, 5'd5));
        port_q[0].push_back(mk(OP_RS, 12'h301, 2'd1, 1'b1, 5'd0));
        drain(10);

        // access_pending blocks acceptance and freezes the pointer
        clear_logs();
        bus.access_pending = 1'b1;
        rr_before = m_rr;
        port_q[0].push_back(mk(OP_RW, 12'h302, 2'd2, 1'b1, 5'd9));
        port_q[1].push_back(mk(OP_RS, 12'h303, 2'd3, 1'b1, 5'd1));
        for (int i = 0; i < 3; i++) step();
        check("ap_no_grant", grant_log.size(), 0);
        bus.access_pending = 1'b0;
        step();
        check("ap_grant_seen", grant_log.size(), 1);
        if (grant_log.size() != 0) check("ap_rr_hold", grant_log[0], rr_before);
        drain(10);

        // Backpressure: 6 offered, 4 fit, then one accept per pop
        clear_logs();
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            port_q[0].push_back(mk(OP_RS, SCR + 12'(i), 2'(i), 1'b1, 5'(i)));
            port_q[1].push_back(mk(OP_RS, 12'h300 + 12'(i), 2'(i), 1'b1, 5'd0));
        end
        for (int i = 0; i < 6; i++) step();
        check("bp_accepts", grant_log.size(), RSP_DEPTH);
        check("bp_ready_low", bus.req_ready & bus.req_valid, 2'b00);
        bus.rsp_ready = 1'b1;
        drain(20);
        check("bp_pending_done", bus.req_pending, 1'b0);

        // Asynchronous reset with three queued responses
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) port_q[0].push_back(mk(OP_RS, CSR_WTID, 2'd0, 1'b1, 5'd0));
        for (int i = 0; i < 3; i++) step();
        check("ar_queued", bus.req_pending, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("ar_rsp_valid", bus.rsp_valid, 1'b0);
        check("ar_req_pending", bus.req_pending, 1'b0);
        check("ar_req_ready", bus.req_ready, 2'b00);
        check("ar_be_en", {bus.be_read_enable, bus.be_write_enable}, 2'b00);
        m_q.delete(); port_q[0].delete(); port_q[1].delete(); m_rr = 0;
        for (int w = 0; w < NW; w++) for (int s = 0; s < NUM_SCRATCH; s++) m_scratch[w][s] = '0;
        @(posedge clk); @(posedge clk); #2 reset = 1'b1;
        bus.rsp_ready = 1'b1;
        clear_logs();
        port_q[0].push_back(mk(OP_RS, SCR, 2'd1, 1'b1, 5'd0));
        drain(10);
        check("ar_sc_count", data_log.size(), 1);
        if (data_log.size() != 0) check("ar_scratch_zero", data_log[0], 32'h0);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < NUM_REQS; p++) begin
                if (port_q[p].size() < 3 && $urandom_range(99) < 60) begin
                    logic [11:0] a;
                    case ($urandom_range(2))
                        0: a = CSR_WTID + 12'($urandom_range(4));
                        1: a = SCR + 12'($urandom_range(NUM_SCRATCH - 1));
                        default: a = 12'h300 + 12'($urandom_range(3));
                    endcase
                    r = mk(2'($urandom_range(3, 1)), a, 2'($urandom), 1'($urandom), 5'($urandom));
                    if ($urandom_range(3) == 0) begin
                        r.rs1[r.tid] = '0;
                        r.imm = '0;
                    end
                    port_q[p].push_back(r);
                end
            end
            bus.rsp_ready = ($urandom_range(99) < 70);
            bus.access_pending = ($urandom_range(99) < 10);
            step();
        end
        bus.rsp_ready = 1'b1;
        bus.access_pending = 1'b0;
        drain(100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
